// File: rtl/rtl_settings_pkg.sv
// rtl/rtl_settings_pkg.sv - shared types, widths and helper functions for the compare engine
// Purpose: command/log record layouts, FSM state encoding, byte-mask, LFSR and
//          priority-encode helpers used by cmp_engine and its sub-modules.
package rtl_settings_pkg;

  localparam int ADDR_W    = 32;   // command word-address width
  localparam int BURST_W   = 11;   // word-count field width (words minus 1)
  localparam int OFF_W     = 8;    // byte offset / byte number width
  localparam int MAX_BYTES = 256;  // widest word the helpers cover, in bytes

  typedef struct packed {
    logic [ADDR_W-1:0]  start_addr;
    logic [BURST_W-1:0] words;
    logic [OFF_W-1:0]   start_off;
    logic [OFF_W-1:0]   end_off;
    logic [7:0]         ptrn;
    logic               rnd;
  } cmp_cmd_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [OFF_W-1:0]  byte_num;
    logic [7:0]        exp_byte;
    logic [7:0]        got_byte;
  } err_log_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_HALT} cmp_state_t;

  // Bytes checked in a word: first word starts at start_off, last word stops at end_off.
  function automatic logic [MAX_BYTES-1:0] byte_mask(input logic first, input logic [OFF_W-1:0] start_off,
                                                     input logic last, input logic [OFF_W-1:0] end_off);
    for (int i = 0; i < MAX_BYTES; i++)
      byte_mask[i] = (!first || OFF_W'(i) >= start_off) && (!last || OFF_W'(i) <= end_off);
  endfunction

  function automatic logic [7:0] lfsr8_next(input logic [7:0] p);
    return {p[6:0], p[6] ^ p[1] ^ p[0]};
  endfunction

  function automatic logic [OFF_W-1:0] lowest_set(input logic [MAX_BYTES-1:0] vec);
    lowest_set = '0;
    for (int i = MAX_BYTES - 1; i >= 0; i--)
      if (vec[i]) lowest_set = OFF_W'(i);
  endfunction

endpackage

// File: rtl/cmp_err_log.sv
// rtl/cmp_err_log.sv - first-N error log: register array, write pointer, saturating count
// Ports: clk_i/rst_i (async active-high), i_clr (sync clear of count), i_wr/i_entry write,
//        i_idx read index, o_entry combinational read, o_cnt number of valid entries.
module cmp_err_log
  import rtl_settings_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH)
)(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_clr,
  input  logic          i_wr,
  input  err_log_t      i_entry,
  input  logic [LW-1:0] i_idx,
  output err_log_t      o_entry,
  output logic [LW:0]   o_cnt
);
  err_log_t   r_log [DEPTH];
  logic [LW:0] r_cnt;

  assign o_entry = r_log[i_idx];
  assign o_cnt   = r_cnt;

  // The count doubles as the write pointer; its top bit means the log is full.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_log[i] <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_wr && !r_cnt[LW]) begin
      r_log[r_cnt[LW-1:0]] <= i_entry;
      r_cnt <= r_cnt + (LW+1)'(1);
    end
  end
endmodule

// File: rtl/fifo.sv
// rtl/fifo.sv - show-ahead synchronous FIFO shared by the command and read-data queues
// Ports: clk_i/rst_i (async active-high), i_clr (sync flush), i_push/i_data write side,
//        i_pop/o_data read side (o_data valid whenever !o_empty), o_empty, o_full.
module fifo #(
  parameter int W  = 8,
  parameter int AW = 2
)(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);
  logic [W-1:0]  r_mem [2**AW];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;

  // Push while full and pop while empty are both ignored.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_empty = (r_cnt == '0);
  assign o_full  = r_cnt[AW];
  assign o_data  = r_mem[r_rp];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end
endmodule

// File: rtl/cmp_engine.sv
// rtl/cmp_engine.sv - read-data checker: compares returned words against fixed/LFSR byte patterns
// Ports: clk_i/rst_i (async active-high); test_start_i sync clear; stop_on_err_i halt policy;
//        readdatavalid_i/readdata_i AMM read data; cmd_valid_i/cmd_ready_o/cmd_i command queue;
//        busy_o, err_stb_o, err_cnt_o, halted_o, ovf_o status; log_idx_i/log_entry_o/log_cnt_o log.
module cmp_engine
  import rtl_settings_pkg::*;
#(
  parameter int DATA_W        = 128,
  parameter int CMD_FIFO_AW   = 2,
  parameter int DATA_FIFO_AW  = 6,
  parameter int ERR_LOG_DEPTH = 4,
  localparam int LW           = $clog2(ERR_LOG_DEPTH)
)(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_start_i,
  input  logic              stop_on_err_i,
  input  logic              readdatavalid_i,
  input  logic [DATA_W-1:0] readdata_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  cmp_cmd_t          cmd_i,
  output logic              busy_o,
  output logic              err_stb_o,
  output logic [31:0]       err_cnt_o,
  output logic              halted_o,
  output logic              ovf_o,
  input  logic [LW-1:0]     log_idx_i,
  output err_log_t          log_entry_o,
  output logic [LW:0]       log_cnt_o
);
  localparam int NB = DATA_W / 8;

  cmp_state_t        r_state;
  cmp_cmd_t          r_cmd;
  logic [BURST_W-1:0] r_word_cnt;
  logic [ADDR_W-1:0] r_addr, r_s1_addr;
  logic [7:0]        r_pat, r_s1_exp;
  logic              r_first, r_halted, r_ovf, r_s1_vld, r_s2_vld, r_err_stb;
  logic [NB-1:0]     r_s1_mm;
  logic [DATA_W-1:0] r_s1_data;
  logic [31:0]       r_err_cnt;

  cmp_cmd_t          w_cmd_q;
  logic              w_cmd_empty, w_cmd_full, w_cmd_pop;
  logic [DATA_W-1:0] w_dq;
  logic              w_dempty, w_dfull, w_dpop, w_last, w_s1_err;
  logic [MAX_BYTES-1:0] w_mask_full;
  logic [NB-1:0]     w_mm;
  logic [OFF_W-1:0]  w_idx;
  logic [7:0]        w_got;
  err_log_t          w_entry;
  logic              w_unused_mask;

  fifo #(.W($bits(cmp_cmd_t)), .AW(CMD_FIFO_AW)) u_cmd_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .i_clr(test_start_i), .i_push(cmd_valid_i), .i_data(cmd_i),
    .i_pop(w_cmd_pop), .o_data(w_cmd_q), .o_empty(w_cmd_empty), .o_full(w_cmd_full));

  fifo #(.W(DATA_W), .AW(DATA_FIFO_AW)) u_data_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .i_clr(test_start_i), .i_push(readdatavalid_i), .i_data(readdata_i),
    .i_pop(w_dpop), .o_data(w_dq), .o_empty(w_dempty), .o_full(w_dfull));

  // A command is not taken in the cycle that is about to halt, so it stays queued.
  assign w_cmd_pop = (r_state == S_IDLE) & ~w_cmd_empty & ~(r_err_stb & stop_on_err_i);
  assign w_dpop    = (r_state == S_CHECK) & ~w_dempty;
  assign w_last    = (r_word_cnt == '0);
  assign w_s1_err  = r_s1_vld & (|r_s1_mm);

  // Helpers cover up to MAX_BYTES; only the low NB mask bits matter here.
  assign w_mask_full   = byte_mask(r_first, r_cmd.start_off, w_last, r_cmd.end_off);
  assign w_unused_mask = ^w_mask_full[MAX_BYTES-1:NB];

  always_comb begin
    w_mm = '0;
    for (int i = 0; i < NB; i++)
      w_mm[i] = w_mask_full[i] & (w_dq[8*i +: 8] != r_pat);
  end

  assign w_idx = lowest_set(MAX_BYTES'(r_s1_mm));

  always_comb begin
    w_got = '0;
    for (int i = 0; i < NB; i++)
      if (w_idx == OFF_W'(i)) w_got = r_s1_data[8*i +: 8];
  end

  assign w_entry = '{addr: r_s1_addr, byte_num: w_idx, exp_byte: r_s1_exp, got_byte: w_got};

  cmp_err_log #(.DEPTH(ERR_LOG_DEPTH)) u_log (
    .clk_i(clk_i), .rst_i(rst_i), .i_clr(test_start_i), .i_wr(w_s1_err), .i_entry(w_entry),
    .i_idx(log_idx_i), .o_entry(log_entry_o), .o_cnt(log_cnt_o));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;  r_cmd <= '0;      r_word_cnt <= '0; r_addr <= '0;
      r_pat <= '0;        r_first <= 1'b0;  r_halted <= 1'b0; r_ovf <= 1'b0;
      r_s1_vld <= 1'b0;   r_s1_mm <= '0;    r_s1_data <= '0;  r_s1_addr <= '0;
      r_s1_exp <= '0;     r_s2_vld <= 1'b0; r_err_stb <= 1'b0; r_err_cnt <= '0;
    end else if (test_start_i) begin
      r_state <= S_IDLE;  r_halted <= 1'b0; r_ovf <= 1'b0;    r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;   r_err_stb <= 1'b0; r_err_cnt <= '0;
    end else begin
      if (readdatavalid_i && w_dfull) r_ovf <= 1'b1;
      // Stage 1: masked per-byte mismatch of the popped word.
      r_s1_vld <= w_dpop;
      if (w_dpop) begin
        r_s1_mm   <= w_mm;
        r_s1_data <= w_dq;
        r_s1_addr <= r_addr;
        r_s1_exp  <= r_pat;
      end
      // Stage 2: strobe and count; the log is written on the same edge.
      r_s2_vld  <= r_s1_vld;
      r_err_stb <= w_s1_err;
      if (w_s1_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 32'd1;
      case (r_state)
        S_IDLE: if (w_cmd_pop) begin
          r_cmd   <= w_cmd_q;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_word_cnt <= r_cmd.words;
          r_addr     <= r_cmd.start_addr;
          r_pat      <= r_cmd.ptrn;
          r_first    <= 1'b1;
          r_state    <= S_CHECK;
        end
        S_CHECK: if (w_dpop) begin
          r_first    <= 1'b0;
          r_word_cnt <= r_word_cnt - BURST_W'(1);
          r_addr     <= r_addr + ADDR_W'(1);
          if (r_cmd.rnd) r_pat <= lfsr8_next(r_pat);
          if (w_last) r_state <= S_IDLE;
        end
        default: ;
      endcase
      if (r_err_stb && stop_on_err_i && r_state != S_HALT) begin
        r_state  <= S_HALT;
        r_halted <= 1'b1;
      end
    end
  end

  assign cmd_ready_o = ~w_cmd_full;
  assign err_stb_o   = r_err_stb;
  assign err_cnt_o   = r_err_cnt;
  assign halted_o    = r_halted;
  assign ovf_o       = r_ovf;
  // Queued commands do not keep a halted engine busy.
  assign busy_o = (r_state == S_LOAD) | (r_state == S_CHECK) | (~w_cmd_empty & ~r_halted)
                | r_s1_vld | r_s2_vld;
endmodule

// File: tb/tb_cmp_engine.sv
// tb/tb_cmp_engine.sv - self-checking bench for cmp_engine
module tb_cmp_engine;
  import rtl_settings_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        test_start_i = 1'b0;
  logic        stop_on_err_i = 1'b0;
  logic        readdatavalid_i = 1'b0;
  logic [31:0] readdata_i = '0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  cmp_cmd_t    cmd_i = '0;
  logic        busy_o, err_stb_o, halted_o, ovf_o;
  logic [31:0] err_cnt_o;
  logic [1:0]  log_idx_i = '0;
  err_log_t    log_entry_o;
  logic [2:0]  log_cnt_o;

  cmp_engine #(.DATA_W(32), .CMD_FIFO_AW(2), .DATA_FIFO_AW(6), .ERR_LOG_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .test_start_i(test_start_i), .stop_on_err_i(stop_on_err_i),
    .readdatavalid_i(readdatavalid_i), .readdata_i(readdata_i), .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o), .cmd_i(cmd_i), .busy_o(busy_o), .err_stb_o(err_stb_o),
    .err_cnt_o(err_cnt_o), .halted_o(halted_o), .ovf_o(ovf_o), .log_idx_i(log_idx_i),
    .log_entry_o(log_entry_o), .log_cnt_o(log_cnt_o));

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {int due; logic err;} sb_t;
  sb_t  sbq[$];
  logic sb_on = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Strobe timing: a word driven in cycle M is popped in M+1 and strobes in M+3.
  always @(negedge clk_i) begin
    if (sb_on) begin
      logic e;
      e = 1'b0;
      if (sbq.size() > 0 && sbq[0].due == cyc) e = sbq.pop_front().err;
      check("err_stb", err_stb_o, e);
    end
  end

  task automatic push_cmd(input logic [31:0] a, input logic [10:0] w, input logic [7:0] so,
                          input logic [7:0] eo, input logic [7:0] p, input logic r);
    cmd_i = '{start_addr: a, words: w, start_off: so, end_off: eo, ptrn: p, rnd: r};
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    repeat (4) tick();
  endtask

  task automatic send_word(input logic [31:0] d, input logic e);
    readdatavalid_i = 1'b1;
    readdata_i = d;
    if (sb_on) sbq.push_back('{cyc + 3, e});
    tick();
    readdatavalid_i = 1'b0;
  endtask

  task automatic pulse_start();
    test_start_i = 1'b1;
    tick();
    test_start_i = 1'b0;
  endtask

  task automatic check_log(input string tag, input logic [1:0] idx, input logic [31:0] a,
                           input logic [7:0] bn, input logic [7:0] eb, input logic [7:0] gb);
    err_log_t x;
    x = '{addr: a, byte_num: bn, exp_byte: eb, got_byte: gb};
    log_idx_i = idx;
    @(negedge clk_i);
    check(tag, log_entry_o, x);
  endtask

  function automatic logic [7:0] model_lfsr(input logic [7:0] p);
    logic fb;
    fb = p[6] ^ p[1] ^ p[0];
    return (p << 1) | {7'd0, fb};
  endfunction

  initial begin
    logic [7:0] p0, p1, p2;
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_err_cnt", err_cnt_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_halted", halted_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_log_cnt", log_cnt_o, 0);
    check("rst_err_stb", err_stb_o, 0);

    // Fixed pattern, all words match; busy drops 3 cycles after the last pop.
    sb_on = 1'b1;
    push_cmd(32'h100, 11'd3, 8'd0, 8'd3, 8'hA5, 1'b0);
    repeat (4) send_word(32'hA5A5A5A5, 1'b0);
    tick(); tick();
    @(negedge clk_i);
    check("busy_tail", busy_o, 1);
    tick();
    @(negedge clk_i);
    check("busy_fall", busy_o, 0);
    check("a_err_cnt", err_cnt_o, 0);

    // Word 2 byte 1 corrupted.
    push_cmd(32'h100, 11'd3, 8'd0, 8'd3, 8'hA5, 1'b0);
    send_word(32'hA5A5A5A5, 1'b0);
    send_word(32'hA5A5A5A5, 1'b0);
    send_word(32'hA5A500A5, 1'b1);
    send_word(32'hA5A5A5A5, 1'b0);
    repeat (5) tick();
    check("b_err_cnt", err_cnt_o, 1);
    check("b_busy", busy_o, 0);
    check_log("b_log0", 2'd0, 32'h102, 8'd1, 8'hA5, 8'h00);

    // LFSR pattern.
    p0 = 8'h01;
    p1 = model_lfsr(p0);
    p2 = model_lfsr(p1);
    push_cmd(32'h200, 11'd2, 8'd0, 8'd3, 8'h01, 1'b1);
    send_word({4{p0}}, 1'b0);
    send_word({4{p1}}, 1'b0);
    send_word({4{p2}}, 1'b0);
    repeat (5) tick();
    check("c_err_cnt_clean", err_cnt_o, 1);
    push_cmd(32'h200, 11'd2, 8'd0, 8'd3, 8'h01, 1'b1);
    send_word({4{p0}}, 1'b0);
    send_word({p1, p1, p1, 8'h00}, 1'b1);
    send_word({4{p2}}, 1'b0);
    repeat (5) tick();
    check("c_err_cnt", err_cnt_o, 2);
    check_log("c_log1", 2'd1, 32'h201, 8'd0, 8'h03, 8'h00);

    // Start/end offsets mask out-of-range bytes.
    push_cmd(32'h300, 11'd1, 8'd2, 8'd1, 8'h5A, 1'b0);
    send_word(32'h5A5A0000, 1'b0);
    send_word(32'h00005A5A, 1'b0);
    repeat (5) tick();
    check("d_masked", err_cnt_o, 2);
    push_cmd(32'h300, 11'd1, 8'd2, 8'd1, 8'h5A, 1'b0);
    send_word(32'h5A005A5A, 1'b1);
    send_word(32'h5A5A5A5A, 1'b0);
    repeat (5) tick();
    check("d_err_cnt", err_cnt_o, 3);
    check("d_log_cnt", log_cnt_o, 3);
    check_log("d_log2", 2'd2, 32'h300, 8'd2, 8'h5A, 8'h00);
    check("sb_drained", sbq.size(), 0);

    // Halt on error with in-flight drain.
    sb_on = 1'b0;
    pulse_start();
    @(negedge clk_i);
    check("e_clr_cnt", err_cnt_o, 0);
    check("e_clr_log", log_cnt_o, 0);
    stop_on_err_i = 1'b1;
    push_cmd(32'h400, 11'd7, 8'd0, 8'd3, 8'hFF, 1'b0);
    repeat (8) send_word(32'h00000000, 1'b1);
    repeat (20) tick();
    check("e_halted", halted_o, 1);
    check("e_cnt_range", (err_cnt_o >= 1) && (err_cnt_o <= 3), 1);
    check("e_busy_drained", busy_o, 0);
    pulse_start();
    @(negedge clk_i);
    check("e2_halted", halted_o, 0);
    check("e2_cnt", err_cnt_o, 0);
    check("e2_busy", busy_o, 0);
    check("e2_log", log_cnt_o, 0);

    // Clear on the same edge as the error strobe wins.
    stop_on_err_i = 1'b0;
    push_cmd(32'h500, 11'd0, 8'd0, 8'd3, 8'h11, 1'b0);
    send_word(32'h00000000, 1'b1);
    tick();
    pulse_start();
    @(negedge clk_i);
    check("f_cnt", err_cnt_o, 0);
    check("f_stb", err_stb_o, 0);
    check("f_log", log_cnt_o, 0);

    // More errors than log entries.
    sb_on = 1'b1;
    push_cmd(32'h600, 11'd5, 8'd0, 8'd3, 8'h33, 1'b0);
    repeat (6) send_word(32'h00000000, 1'b1);
    repeat (5) tick();
    check("g_cnt", err_cnt_o, 6);
    check("g_log_cnt", log_cnt_o, 4);
    check_log("g_log3", 2'd3, 32'h603, 8'd0, 8'h33, 8'h00);
    check("g_sb_drained", sbq.size(), 0);

    // Overflow of the data FIFO while halted.
    sb_on = 1'b0;
    stop_on_err_i = 1'b1;
    push_cmd(32'h700, 11'd200, 8'd0, 8'd3, 8'h33, 1'b0);
    send_word(32'h00000000, 1'b1);
    repeat (6) tick();
    check("h_halted", halted_o, 1);
    check("h_cnt", err_cnt_o, 7);
    check("h_log_cnt", log_cnt_o, 4);
    repeat (64) send_word(32'h33333333, 1'b0);
    @(negedge clk_i);
    check("h_ovf_full", ovf_o, 0);
    send_word(32'h33333333, 1'b0);
    @(negedge clk_i);
    check("h_ovf", ovf_o, 1);
    check("h_busy", busy_o, 0);
    pulse_start();
    @(negedge clk_i);
    check("h_ovf_clr", ovf_o, 0);
    check("h_halt_clr", halted_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
